// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with a double-buffered BCD value.
// Each digit gets GAP dark cycles and then DWELL lit cycles. New values only take effect between frames.
module seg7_scan_ctrl #(
   parameter int DWELL = 1000,
   parameter int GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic        blank_lz,
   output logic [3:0]  digit_bcd,
   output logic [3:0]  an,
   output logic        frame_done,
   output logic        bad_digit
);

   localparam int MAXC = (GAP > DWELL) ? GAP : DWELL;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

   typedef enum logic {BLANK, SHOW} phase_t;

   phase_t        phase, phase_n;
   logic [1:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   active, pending;
   logic          pending_full;
   logic          accept;
   logic [3:0]    cur_digit;
   logic [3:0]    lead_zero;
   logic          blanked;

   assign accept     = load_valid && !pending_full;
   assign load_ready = !pending_full;
   assign frame_done = (phase == SHOW) && (idx == 2'd3) && (cnt == DWELL_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= BLANK;
         idx   <= 2'd0;
         cnt   <= '0;
      end else begin
         phase <= phase_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      phase_n = phase;
      idx_n   = idx;
      cnt_n   = cnt + 1'b1;
      case (phase)
         BLANK: begin
            if (cnt == GAP_LAST) begin
               phase_n = SHOW;
               cnt_n   = '0;
            end
         end
         SHOW: begin
            if (cnt == DWELL_LAST) begin
               phase_n = BLANK;
               cnt_n   = '0;
               idx_n   = idx + 2'd1;
            end
         end
         default: begin
            phase_n = BLANK;
            cnt_n   = '0;
         end
      endcase
   end

   // Accept and frame-boundary swap are exclusive: accept needs an empty pending slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         active       <= 16'h0000;
         pending      <= 16'h0000;
         pending_full <= 1'b0;
      end else if (accept) begin
         pending      <= load_data;
         pending_full <= 1'b1;
      end else if (frame_done && pending_full) begin
         active       <= pending;
         pending_full <= 1'b0;
      end
   end

   // lead_zero[k] is set when digit k and every digit above it are zero; digit0 is never blanked.
   always_comb begin
      lead_zero[3] = (active[15:12] == 4'h0);
      lead_zero[2] = lead_zero[3] && (active[11:8] == 4'h0);
      lead_zero[1] = lead_zero[2] && (active[7:4] == 4'h0);
      lead_zero[0] = 1'b0;
   end

   always_comb begin
      cur_digit = active[{idx, 2'b00} +: 4];
      blanked   = blank_lz && lead_zero[idx];
      an        = 4'b1111;
      digit_bcd = 4'hF;
      bad_digit = 1'b0;
      if (phase == SHOW) begin
         an = ~(4'b0001 << idx);
         if (!blanked) begin
            digit_bcd = cur_digit;
            bad_digit = (cur_digit > 4'd9);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position model predicts every output cycle.
// The monitor compares those predictions on the falling edge.
module tb_seg7_scan_ctrl;

   localparam int DWELL = 4;
   localparam int GAP   = 1;
   localparam int PER   = GAP + DWELL;
   localparam int FRAME = 4 * PER;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        blank_lz;
   logic [3:0]  digit_bcd;
   logic [3:0]  an;
   logic        frame_done;
   logic        bad_digit;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       ready;
      logic       fd;
      logic       bad;
   } exp_t;

   exp_t exp_q[$];

   int check_count = 0;
   int pass_count  = 0;
   int cycle       = 0;

   // Reference model state: position within the frame plus the two value buffers.
   int          m_pos  = 0;
   logic [15:0] m_active = 16'h0;
   logic [15:0] m_pend   = 16'h0;
   logic        m_full   = 1'b0;

   seg7_scan_ctrl #(.DWELL(DWELL), .GAP(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .blank_lz   (blank_lz),
      .digit_bcd  (digit_bcd),
      .an         (an),
      .frame_done (frame_done),
      .bad_digit  (bad_digit)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
   endtask

   task automatic applyStimulus(input logic r, input logic lv, input logic [15:0] ld,
                                input logic blz, input int n);
      rst        = r;
      load_valid = lv;
      load_data  = ld;
      blank_lz   = blz;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic waitPos(input int target);
      int guard = 0;
      while (m_pos != target && guard < 2 * FRAME) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("wait_pos", 16'(m_pos), 16'(target));
   endtask

   function automatic exp_t predict(input int pos, input logic [15:0] act,
                                    input logic full, input logic blz);
      exp_t e;
      int   k;
      logic show, blanked;
      logic [3:0] d;
      k       = pos / PER;
      show    = (pos % PER) >= GAP;
      d       = 4'((act >> (4 * k)) & 16'hF);
      blanked = blz && (k > 0) && ((act >> (4 * k)) == 16'h0);
      e.an    = show ? 4'(~(1 << k)) : 4'hF;
      e.bcd   = (show && !blanked) ? d : 4'hF;
      e.bad   = show && !blanked && (d > 4'd9);
      e.ready = !full;
      e.fd    = (pos == FRAME - 1);
      return e;
   endfunction

   // Advance the model on each rising edge, then predict the outputs for the new cycle.
   always begin
      @(posedge clk);
      cycle++;
      if (rst) begin
         m_pos    = 0;
         m_active = 16'h0;
         m_full   = 1'b0;
      end else begin
         if (load_valid && !m_full) begin
            m_pend = load_data;
            m_full = 1'b1;
         end else if (m_pos == FRAME - 1 && m_full) begin
            m_active = m_pend;
            m_full   = 1'b0;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      #2;
      exp_q.push_back(predict(m_pos, m_active, m_full, blank_lz));
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput("sb_empty", 16'(exp_q.size()), 16'd1);
      end else begin
         e = exp_q.pop_front();
         checkOutput("an",         16'(an),         16'(e.an));
         checkOutput("digit_bcd",  16'(digit_bcd),  16'(e.bcd));
         checkOutput("load_ready", 16'(load_ready), 16'(e.ready));
         checkOutput("frame_done", 16'(frame_done), 16'(e.fd));
         checkOutput("bad_digit",  16'(bad_digit),  16'(e.bad));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] data;
      logic        blz;
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 25);

      // A second offer while pending is full must be dropped.
      applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 16'h5678, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 45);

      applyStimulus(1'b0, 1'b1, 16'h0042, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 40);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 20);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 45);
      applyStimulus(1'b0, 1'b1, 16'h00A1, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 45);

      // Reset in the middle of digit2's lit window with a load still pending.
      waitPos(1);
      applyStimulus(1'b0, 1'b1, 16'h9999, 1'b1, 1);
      load_valid = 1'b0;
      waitPos(GAP + 2 * PER + 1);
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 45);

      blz = 1'b1;
      for (int i = 0; i < 700; i++) begin
         data = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         if ($urandom_range(0, 6) == 0) blz = 1'($urandom);
         applyStimulus(($urandom_range(0, 149) == 0), 1'($urandom), data, blz, 1);
      end

      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 3);
      @(negedge clk);
      #1;
      checkOutput("sb_drain", 16'(exp_q.size()), 16'd0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 1000: cycles each digit is lit per frame; SHALL be >=1.
REQ-002 Parameter GAP, default 2: all-anodes-off cycles before each digit (anti-ghosting); SHALL be >=1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; reset is synchronous and active-high.
REQ-005 load_valid  input  1  requester offers new 4-digit BCD value.
REQ-006 load_data  input  16  four BCD digits; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007 load_ready  output  1  block can accept a load this cycle.
REQ-008 blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
REQ-009 digit_bcd  output  4  code fed to the BCD-to-7-segment decoder; 4'hF means blank.
REQ-010 an  output  4  digit enables, active-low, one-hot-low or 4'b1111.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full scan frame.
REQ-012 bad_digit  output  1  currently shown digit is >9.

Function
REQ-013 The block SHALL hold an active register (16 bits), a pending register (16 bits) with pending_full flag, a 2-bit digit index, a phase FSM {BLANK, SHOW}, and a dwell counter.
REQ-014 The FSM SHALL cycle per digit: BLANK for GAP cycles, then SHOW for DWELL cycles, then BLANK for the next digit; digit order 0,1,2,3, wrapping 3->0.
REQ-015 Frame length SHALL be exactly 4*(GAP+DWELL) cycles.
REQ-016 In BLANK: an=4'b1111, digit_bcd=4'hF, bad_digit=0.
REQ-017 In SHOW for index k: an has bit k low and all others high; digit_bcd = active digit k, or 4'hF if blanked per REQ-018.
REQ-018 With blank_lz=1, digit k (k=1..3) SHALL be blanked when it and all higher digits are 4'h0; digit0 SHALL never be blanked.
REQ-019 bad_digit SHALL be 1 only in SHOW when the unblanked digit value is >9; that value SHALL still be passed on digit_bcd unchanged.
REQ-020 load_ready SHALL equal !pending_full.
REQ-021 A load is accepted when load_valid && load_ready at a rising edge; load_data is captured into pending and pending_full is set.
REQ-022 frame_done SHALL be 1 exactly during the last SHOW cycle of digit 3.
REQ-023 On the edge ending a frame_done cycle, if pending_full then active<=pending and pending_full<=0; the next frame (starting at digit0 BLANK) SHALL show the new value; no mid-frame change of active is allowed.
REQ-024 Simultaneous accept and frame boundary cannot collide with a full pending (ready low); if pending was empty, the load goes to pending and is applied at the following boundary.
REQ-025 load_valid while load_ready=0 SHALL be ignored without side effects; requester holds it.
REQ-026 All outputs SHALL derive from registered state and active/pending registers plus blank_lz only; no combinational path from load_valid/load_data to any output other than none.

Reset
REQ-027 While rst=1 at an edge: FSM<=BLANK, index<=0, counter<=0, active<=16'h0000, pending_full<=0.
REQ-028 During/after reset outputs SHALL be: an=4'b1111, digit_bcd=4'hF, load_ready=1, frame_done=0, bad_digit=0.
REQ-029 Reset asserted mid-SHOW or with a pending load SHALL discard pending and restart the frame at digit0 BLANK on the next cycle after deassertion.

Verification (DWELL=4, GAP=1)
REQ-030 Reset -> an=1111, digit_bcd=F, load_ready=1; first frame shows 0 on digit0 (blank_lz=1: digits 3..1 show F), frame_done every 20 cycles.
REQ-031 Load 16'h1234 mid-frame -> load_ready=0 next cycle until boundary; next frame: digit0 an=1110 bcd=4 for 4 cycles after 1 blank cycle, then 3,2,1 on an=1101,1011,0111; load_ready=1 after boundary.
REQ-032 Second load while pending full -> ignored; value applied is the first one.
REQ-033 blank_lz=1, 16'h0042 -> digits 3,2 show F, digits 1,0 show 4,2; blank_lz=0 -> digits 3,2 show 0; 16'h0000 with blank_lz=1 -> only digit0 shows 0.
REQ-034 16'h00A1 -> digit1 SHOW: digit_bcd=A, bad_digit=1 for 4 cycles; bad_digit=0 elsewhere.
REQ-035 rst pulsed during digit2 SHOW with pending full -> reset values per REQ-028; pending lost; next frame shows 16'h0000.
